// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I write-back types and constants
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed byte/half of a loaded word
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = 32'h0000_0000;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h00_0000, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0000, half_sel};
            F3_LW:   result = word;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I MEM/WB register, result mux and reg_file write gating (option: WB_INSTRET_EN)
module wb_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [1:0]            mem_wb_sel,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_load_word,
    input  logic [XLEN-1:0]       mem_pc_plus4,
    input  logic                  stall,
    input  logic                  flush,
`ifdef WB_INSTRET_EN
    output logic [63:0]           instret,
`endif
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       rd_data,
    output logic                  we,
    output logic                  retire
);

    logic                  valid_q;
    logic                  committed_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    wb_sel_e               wb_sel_q;
    logic [2:0]            funct3_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       load_q;
    logic [XLEN-1:0]       pc4_q;
    logic [XLEN-1:0]       load_data;

    // committed marks an instruction that already wrote while being held by stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            committed_q <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= WB_ALU;
            funct3_q    <= 3'b000;
            alu_q       <= '0;
            load_q      <= '0;
            pc4_q       <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            committed_q <= 1'b0;
        end else if (stall) begin
            committed_q <= committed_q | valid_q;
        end else begin
            valid_q     <= mem_valid;
            committed_q <= 1'b0;
            rd_q        <= mem_rd;
            reg_write_q <= mem_reg_write;
            wb_sel_q    <= wb_sel_e'(mem_wb_sel);
            funct3_q    <= mem_funct3;
            alu_q       <= mem_alu_result;
            load_q      <= mem_load_word;
            pc4_q       <= mem_pc_plus4;
        end
    end

    load_align u_load_align (
        .funct3 (funct3_q),
        .offset (alu_q[1:0]),
        .word   (load_q),
        .result (load_data)
    );

    always_comb begin
        rd_data = '0;
        case (wb_sel_q)
            WB_ALU:  rd_data = alu_q;
            WB_LOAD: rd_data = load_data;
            WB_PC4:  rd_data = pc4_q;
            default: rd_data = '0;
        endcase
    end

    assign rd     = rd_q;
    assign retire = valid_q & ~committed_q;
    assign we     = retire & reg_write_q & (rd_q != '0);

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= 64'd0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_word;
    logic [31:0] mem_pc_plus4;
    logic        stall;
    logic        flush;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        we;
    logic        retire;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_ALU = 2'b00;
    localparam logic [1:0] S_LD  = 2'b01;
    localparam logic [1:0] S_PC4 = 2'b10;
    localparam logic [31:0] LW_WORD = 32'h80FF_7F01;

    wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_load_word  (mem_load_word),
        .mem_pc_plus4   (mem_pc_plus4),
        .stall          (stall),
        .flush          (flush),
`ifdef WB_INSTRET_EN
        .instret        (instret),
`endif
        .rd             (rd),
        .rd_data        (rd_data),
        .we             (we),
        .retire         (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic w, input logic [1:0] s,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4);
        mem_valid      = v;
        mem_rd         = r;
        mem_reg_write  = w;
        mem_wb_sel     = s;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_load_word  = ld;
        mem_pc_plus4   = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_we, input logic [4:0] e_rd,
                              input logic [31:0] e_data, input logic e_ret);
        check({tag, ".we"}, {63'd0, we}, {63'd0, e_we});
        if (e_we) check({tag, ".rd"}, {59'd0, rd}, {59'd0, e_rd});
        check({tag, ".rd_data"}, {32'd0, rd_data}, {32'd0, e_data});
        check({tag, ".retire"}, {63'd0, retire}, {63'd0, e_ret});
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, S_ALU, 3'd0, 32'd0, 32'd0, 32'd0);
        #12;
        check("reset.rd", {59'd0, rd}, 64'd0);
        expect_out("reset", 1'b0, 5'd0, 32'd0, 1'b0);
`ifdef WB_INSTRET_EN
        check("reset.instret", instret, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        drive(1'b1, 5'd5, 1'b1, S_ALU, 3'd0, 32'h0000_1234, 32'd0, 32'd0);
        tick();
        expect_out("alu", 1'b1, 5'd5, 32'h0000_1234, 1'b1);

        drive(1'b1, 5'd7, 1'b1, S_LD, 3'b000, 32'h0000_1003, LW_WORD, 32'd0);
        tick();
        expect_out("lb3", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1);
        drive(1'b1, 5'd7, 1'b1, S_LD, 3'b100, 32'h0000_1001, LW_WORD, 32'd0);
        tick();
        expect_out("lbu1", 1'b1, 5'd7, 32'h0000_007F, 1'b1);
        drive(1'b1, 5'd8, 1'b1, S_LD, 3'b001, 32'h0000_1002, LW_WORD, 32'd0);
        tick();
        expect_out("lh2", 1'b1, 5'd8, 32'hFFFF_80FF, 1'b1);
        drive(1'b1, 5'd8, 1'b1, S_LD, 3'b101, 32'h0000_1000, LW_WORD, 32'd0);
        tick();
        expect_out("lhu0", 1'b1, 5'd8, 32'h0000_7F01, 1'b1);
        drive(1'b1, 5'd9, 1'b1, S_LD, 3'b010, 32'h0000_1003, LW_WORD, 32'd0);
        tick();
        expect_out("lw", 1'b1, 5'd9, 32'h80FF_7F01, 1'b1);
        drive(1'b1, 5'd9, 1'b1, S_LD, 3'b011, 32'h0000_1000, LW_WORD, 32'd0);
        tick();
        expect_out("ld011", 1'b1, 5'd9, 32'h0000_0000, 1'b1);

        drive(1'b1, 5'd0, 1'b1, S_ALU, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        tick();
        expect_out("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        drive(1'b1, 5'd1, 1'b1, S_PC4, 3'd0, 32'h0000_0200, 32'd0, 32'h0000_0104);
        tick();
        expect_out("jal", 1'b1, 5'd1, 32'h0000_0104, 1'b1);

        // ADDI x2=7 then hold it three cycles while the next instruction waits upstream
        drive(1'b1, 5'd2, 1'b1, S_ALU, 3'd0, 32'd7, 32'd0, 32'd0);
        tick();
        expect_out("stall.first", 1'b1, 5'd2, 32'd7, 1'b1);
        drive(1'b1, 5'd11, 1'b1, S_ALU, 3'd0, 32'd99, 32'd0, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("stall.hold%0d", i), 1'b0, 5'd2, 32'd7, 1'b0);
            check($sformatf("stall.rd%0d", i), {59'd0, rd}, 64'd2);
        end
        stall = 1'b0;
        tick();
        expect_out("stall.next", 1'b1, 5'd11, 32'd99, 1'b1);

        drive(1'b1, 5'd3, 1'b1, S_ALU, 3'd0, 32'd55, 32'd0, 32'd0);
        flush = 1'b1;
        tick();
        check("flush.we", {63'd0, we}, 64'd0);
        check("flush.retire", {63'd0, retire}, 64'd0);
        flush = 1'b0;
        tick();
        expect_out("flush.after", 1'b1, 5'd3, 32'd55, 1'b1);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        check("flstall.we", {63'd0, we}, 64'd0);
        check("flstall.retire", {63'd0, retire}, 64'd0);
        flush = 1'b0;
        stall = 1'b0;

        drive(1'b1, 5'd6, 1'b1, S_ALU, 3'd0, 32'h0000_0055, 32'd0, 32'd0);
        tick();
        expect_out("pre_rst", 1'b1, 5'd6, 32'h0000_0055, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst.rd", {59'd0, rd}, 64'd0);
        expect_out("midrst", 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

`ifdef WB_INSTRET_EN
        check("instret.zero", instret, 64'd0);
        drive(1'b1, 5'd4, 1'b1, S_ALU, 3'd0, 32'd1, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b0, 5'd0, 1'b0, S_ALU, 3'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("instret.four", instret, 64'd4);
        #2;
        reset = 1'b1;
        #1;
        check("instret.reset", instret, 64'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
